// File: rtl/seq_divider32.sv
// seq_divider32: unsigned radix-2 restoring divider, one quotient bit per clock.
// Operands are captured in IDLE, the quotient is developed MSB first in CALC,
// and the result is held in DONE until the consumer takes it.
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dvsr;        // captured divisor
    logic [WIDTH-1:0] dq;          // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem;         // partial remainder
    logic [CW-1:0]    count;       // iterations left
    logic             dbz;

    logic             accept;
    logic [WIDTH:0]   rem_shifted;
    logic [WIDTH+1:0] trial;       // {carry-out, rem_shifted - dvsr}
    logic             trial_ok;

    // The partial remainder is always below the divisor between steps, so its
    // top bit is zero there and only the shifted value needs the extra bit.
    logic             unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = dq;
    assign remainder = rem[WIDTH-1:0];
    assign div_by_zero = dbz;

    // Trial subtraction as rem_shifted + ~divisor + 1 at WIDTH+1 bits; the
    // carry-out says whether the subtraction fits (rem_shifted >= divisor).
    always_comb begin
        rem_shifted = {rem[WIDTH-1:0], dq[WIDTH-1]};
        trial       = {1'b0, rem_shifted} + {1'b0, 1'b1, ~dvsr}
                      + {{(WIDTH+1){1'b0}}, 1'b1};
        trial_ok    = trial[WIDTH+1];
    end

    // Control FSM: IDLE -> CALC (or straight to DONE on a zero divisor) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= (divisor == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture on accept, one restoring step per CALC cycle.
    // Nothing is written in DONE, so the result holds until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr  <= '0;
            dq    <= '0;
            rem   <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            dvsr  <= divisor;
            count <= CW'(WIDTH);
            if (divisor == '0) begin
                dq  <= '1;
                rem <= {1'b0, dividend};
                dbz <= 1'b1;
            end else begin
                dq  <= dividend;
                rem <= '0;
                dbz <= 1'b0;
            end
        end else if (state == CALC) begin
            count <= count - 1'b1;
            if (trial_ok) begin
                rem <= trial[WIDTH:0];
                dq  <= {dq[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_shifted;
                dq  <= {dq[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Bench for seq_divider32: directed scenarios plus randomized operations
// checked against plain integer division.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) handshakes++;
    end

    // Reference: unsigned division, zero divisor gives all-ones / dividend.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        dividend = 32'd50;
        divisor = 32'd3;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
            remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h dbz=%b, expected 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int n;
        start_op(32'd100, 32'd7);
        wait_valid(60, n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, expected 32", n);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, expected 14 2 0", quotient, remainder, div_by_zero);
        end
        take_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        $display("test_basic: 100/7 latency=%0d q=%0d r=%0d", n, quotient, remainder);
    endtask

    task automatic test_large_divisor();
        logic [31:0] a_tab [2] = '{32'hFFFF_FFFF, 32'd5};
        logic [31:0] b_tab [2] = '{32'h8000_0001, 32'd9};
        logic [31:0] q_tab [2] = '{32'd1, 32'd0};
        logic [31:0] r_tab [2] = '{32'h7FFF_FFFE, 32'd5};
        int n;
        for (int i = 0; i < 2; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_valid(60, n);
            checks++;
            if (n !== 32 || quotient !== q_tab[i] || remainder !== r_tab[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL large_%0d: lat=%0d q=%h r=%h dbz=%b, expected lat=32 q=%h r=%h dbz=0",
                         i, n, quotient, remainder, div_by_zero, q_tab[i], r_tab[i]);
            end
            $display("test_large_divisor: %h/%h q=%h r=%h", a_tab[i], b_tab[i], quotient, remainder);
            take_result();
        end
    endtask

    task automatic test_div_zero();
        int n;
        start_op(32'h1234_5678, 32'd0);
        wait_valid(60, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL dbz_latency: got %0d extra edges, expected 0 (valid right after accept)", n);
        end
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%h dbz=%b, expected ffffffff 12345678 1",
                     quotient, remainder, div_by_zero);
        end
        take_result();
        $display("test_div_zero: q=%h r=%h", quotient, remainder);
    endtask

    task automatic test_stall();
        int n;
        int bad = 0;
        start_op(32'd100, 32'd7);
        wait_valid(60, n);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd14 ||
                remainder !== 32'd2 || div_by_zero !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, expected 1 0 (no accept on handshake edge)",
                     in_ready, out_valid);
        end
        in_valid = 1'b0;
        tick();
        $display("test_stall: held 10 cycles, released");
    endtask

    task automatic test_reset_abort();
        int n;
        int seen = 0;
        start_op(32'd100, 32'd7);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
            remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b q=%h r=%h dbz=%b, expected 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || quotient !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_accept: in_ready=%b q=%h, expected 1 0", in_ready, quotient);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid seen %0d cycles, expected 0", seen);
        end
        start_op(32'd81, 32'd9);
        wait_valid(60, n);
        checks++;
        if (n !== 32 || quotient !== 32'd9 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d dbz=%b, expected 32 9 0 0",
                     n, quotient, remainder, div_by_zero);
        end
        take_result();
        $display("test_reset_abort: 81/9 q=%0d r=%0d", quotient, remainder);
    endtask

    task automatic test_random();
        localparam int NOPS = 700;
        logic [31:0] a, b, eq, er;
        logic ez;
        int n, stall, kind, hs_start, exp_lat;
        hs_start = handshakes;
        for (int k = 0; k < NOPS; k++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            case (kind)
                0: b = 32'd0;
                1: b = $urandom | 32'h8000_0000;
                2: begin b = $urandom; a = a % (b | 32'd1); end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(a, b, eq, er, ez);
            exp_lat = (b == 0) ? 0 : 32;
            repeat ($urandom_range(0, 2)) tick();
            start_op(a, b);
            dividend = $urandom;
            divisor  = $urandom;
            wait_valid(60, n);
            checks++;
            if (n !== exp_lat || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL random_%0d: %h/%h lat=%0d q=%h r=%h z=%b, expected lat=%0d q=%h r=%h z=%b",
                         k, a, b, n, quotient, remainder, div_by_zero, exp_lat, eq, er, ez);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                in_valid = $urandom_range(0, 1);
                tick();
            end
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL random_hold_%0d: valid=%b q=%h r=%h z=%b, expected 1 %h %h %b",
                         k, out_valid, quotient, remainder, div_by_zero, eq, er, ez);
            end
            take_result();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_once_%0d: out_valid=%b in_ready=%b after handshake, expected 0 1",
                         k, out_valid, in_ready);
            end
        end
        checks++;
        if (handshakes - hs_start != NOPS) begin
            errors++;
            $display("FAIL random_count: %0d results taken, expected %0d", handshakes - hs_start, NOPS);
        end
        $display("test_random: %0d operations", NOPS);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large_divisor();
        test_div_zero();
        test_stall();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
